oam_dma: RTL and testbench
==========================

# oam_dma

Shared-memory controller between the CPU and the OAM DMA engine. Normally passes CPU read/write traffic straight through to the 64 KB `mem` block (8-bit data, 1-cycle registered read latency). A CPU write to `$4014` takes the memory read port, copies the 256-byte page `$XX00–$XXFF` into sprite OAM, and stalls the CPU for 513 or 514 cycles.

## Interface

Parameters:

- `DMA_REG`, `16'h4014`: CPU write address that triggers DMA.
- `ADDR_W`, `16`: memory address width.

Ports:

- `clk`, input, 1: single clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-high.
- `cpu_raddr`, input, 16: CPU read address.
- `cpu_rdata`, output, 8: equals `mem_rdata` (pure passthrough).
- `cpu_wen`, input, 1: CPU write enable.
- `cpu_waddr`, input, 16: CPU write address.
- `cpu_wdata`, input, 8: CPU write data.
- `cpu_stall`, output, 1: CPU must hold its state while this is high.
- `mem_raddr`, output, 16: to `mem` read address.
- `mem_rdata`, input, 8: from `mem`; valid the cycle after its address is sampled.
- `mem_wen`, output, 1: to `mem` write enable.
- `mem_waddr`, output, 16: to `mem` write address.
- `mem_wdata`, output, 8: to `mem` write data.
- `oam_wen`, output, 1: OAM byte write strobe.
- `oam_addr`, output, 8: OAM byte index.
- `oam_wdata`, output, 8: OAM byte data.
- `dma_done`, output, 1: one-cycle pulse in the final WRITE cycle.

## Operation

- **State machine:** IDLE, ALIGN1, ALIGN2, READ, WRITE.
- **Internal registers:**
  - `page[7:0]`.
  - `idx[7:0]`.
  - `parity`: toggles every clock; reset 0.
- **IDLE behaviour:**
  - `mem_raddr = cpu_raddr`.
  - `mem_wen/waddr/wdata` = CPU signals.
  - `cpu_stall = 0`.
- **Trigger:** in IDLE, `cpu_wen && cpu_waddr == DMA_REG` at a posedge.
  - Sets `page <= cpu_wdata`, `idx <= 0`, state `<=` ALIGN1.
  - The trigger write itself is still forwarded to `mem` that cycle.
- **ALIGN1:** if `parity == 1` go to ALIGN2, else go to READ.
- **ALIGN2:** always go to READ.
- **READ:**
  - `mem_raddr = {page, idx}`; next state WRITE.
- **WRITE:**
  - `oam_wen = 1`, `oam_addr = idx`, `oam_wdata = mem_rdata`.
  - If `idx == 8'hFF`: pulse `dma_done`, go to IDLE, `idx` wraps to 0.
  - Else: `idx <= idx + 1` and go to READ.
- **Any non-IDLE state:**
  - `cpu_stall = 1` (combinational from state).
  - `mem_wen = 0`; CPU write inputs are ignored, including further `$4014` writes.
  - `mem_raddr = {page, idx}` (ALIGN states drive it too; the read is harmless).
- **Address arithmetic:** `idx` is 8-bit modulo. The source address never crosses the page; `page = 8'hFF` reads `$FF00–$FFFF`.
- **Reset, at any time including mid-DMA:**
  - State IDLE, `idx = 0`, `page = 0`, `parity = 0`.
  - All outputs deassert in the cycle after the reset edge.
  - OAM bytes already written stay written; there is no resume.

## Timing

- **Reset values:**
  - `cpu_stall = 0`, `oam_wen = 0`, `oam_addr = 0`, `dma_done = 0`, `mem_wen = 0` (when CPU idle).
  - `mem_raddr = cpu_raddr`.
- **Stall start:** `cpu_stall` rises in the cycle after the trigger edge.
- **Stall length:** 1 + (1 if `parity` is 1 in ALIGN1) + 512 cycles, i.e. 513 or 514.
- **Per-byte timing:** read address issued in READ cycle N; data is valid on `mem_rdata` in cycle N+1 (WRITE) and is written combinationally to OAM that cycle. Throughput is 2 cycles per byte.
- **End of DMA:** `cpu_stall` falls in the cycle after the WRITE with `idx == FF`. The CPU may issue a new access, including a new trigger, in that first IDLE cycle.
- **Read-port mux:** combinational on state. The CPU read issued in the last WRITE cycle is not serviced, because the CPU is stalled in that cycle.

## Test plan

1. **Reset and passthrough.**
   - Assert `reset` 2 cycles.
   - Then `cpu_raddr = 16'h1234` with `mem[1234] = 8'hAB` gives `cpu_rdata = AB` one cycle later.
   - `cpu_stall = 0`, `oam_wen = 0` throughout.
2. **Even-parity DMA.**
   - Preload `mem[$0200+i] = i ^ 8'h5A`.
   - Write `8'h02` to `$4014` with `parity` 0 in ALIGN1.
   - Expect `cpu_stall` high for exactly 513 cycles.
   - Expect 256 `oam_wen` pulses with `oam_addr = i`, `oam_wdata = i ^ 5A`, in order.
   - Expect a single `dma_done` coinciding with `oam_addr = FF`.
3. **Odd-parity DMA.**
   - Same stimulus, delayed one cycle so ALIGN1 sees `parity = 1`.
   - Expect a 514-cycle stall and identical OAM contents.
4. **Writes during DMA ignored.**
   - Mid-DMA, drive `cpu_wen = 1` to `$4014` and to `$0300`.
   - Expect `mem_wen = 0` and no restart; `mem[$0300]` unchanged; total stall still 513/514.
5. **Reset mid-DMA.**
   - Assert `reset` after 100 OAM writes.
   - Next cycle expect `cpu_stall = 0` and `oam_wen = 0`; OAM[0..99] hold their values; no further OAM writes.
   - A fresh trigger then runs a full 256-byte copy.
6. **Page wrap and back-to-back.**
   - Trigger with page `FF`: expect reads of `$FF00–$FFFF` only.
   - Retrigger with page `00` in the first IDLE cycle after `dma_done`: expect immediate acceptance and a second full copy.

Source files
------------

// File: rtl/oam_dma.sv
// Shared-memory arbiter between the CPU and the sprite OAM DMA engine.
// A CPU write to DMA_REG copies page {page,00..FF} into OAM while stalling the CPU.
module oam_dma #(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] DMA_REG = 16'h4014
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic [7:0]        cpu_rdata,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              oam_wen,
  output logic [7:0]        oam_addr,
  output logic [7:0]        oam_wdata,
  output logic              dma_done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIGN1 = 3'd1,
    S_ALIGN2 = 3'd2,
    S_READ   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_page;
  logic [7:0]        r_idx;
  logic              r_parity;
  logic              w_trigger;
  logic [ADDR_W-1:0] w_dma_addr;

  assign w_trigger  = (r_state == S_IDLE) && cpu_wen && (cpu_waddr == DMA_REG);
  assign w_dma_addr = ADDR_W'({r_page, r_idx});
  assign cpu_rdata  = mem_rdata;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      r_state  <= w_next_state;
      if (w_trigger) begin
        r_page <= cpu_wdata;
        r_idx  <= 8'h00;
      end else if (r_state == S_WRITE) begin
        // 8-bit wrap returns idx to 0 after the last byte
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    cpu_stall    = 1'b1;
    mem_raddr    = w_dma_addr;
    mem_wen      = 1'b0;
    mem_waddr    = cpu_waddr;
    mem_wdata    = cpu_wdata;
    oam_wen      = 1'b0;
    oam_addr     = r_idx;
    oam_wdata    = mem_rdata;
    dma_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_stall = 1'b0;
        mem_raddr = cpu_raddr;
        mem_wen   = cpu_wen;
        if (w_trigger) w_next_state = S_ALIGN1;
      end
      S_ALIGN1: w_next_state = r_parity ? S_ALIGN2 : S_READ;
      S_ALIGN2: w_next_state = S_READ;
      S_READ:   w_next_state = S_WRITE;
      S_WRITE: begin
        // data requested in READ arrives from mem this cycle
        oam_wen = 1'b1;
        if (r_idx == 8'hFF) begin
          dma_done     = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_READ;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: behavioural mem/OAM models, page shadow as reference,
// randomized pages/data/trigger timing, per-scenario checking tasks.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_raddr;
  logic [7:0]  cpu_rdata;
  logic        cpu_wen;
  logic [15:0] cpu_waddr;
  logic [7:0]  cpu_wdata;
  logic        cpu_stall;
  logic [15:0] mem_raddr;
  logic [7:0]  mem_rdata;
  logic        mem_wen;
  logic [15:0] mem_waddr;
  logic [7:0]  mem_wdata;
  logic        oam_wen;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_done;
  logic [2:0]  dbg_state;

  oam_dma dut (
    .clk(clk), .reset(reset),
    .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .oam_wen(oam_wen), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .dma_done(dma_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // 64 KB memory with one-cycle registered read, and the sprite OAM
  logic [7:0] mem_m [65536];
  logic [7:0] oam_m [256];
  always @(posedge clk) begin
    if (mem_wen) mem_m[mem_waddr] <= mem_wdata;
    mem_rdata <= mem_m[mem_raddr];
  end
  always @(posedge clk) if (oam_wen) oam_m[oam_addr] <= oam_wdata;

  // Free-running parity as described: cleared by reset, toggles every clock
  bit tb_par = 1'b0;
  always @(posedge clk) tb_par <= reset ? 1'b0 : ~tb_par;

  // Reference: shadow of everything the bench wrote into memory
  logic [7:0] shadow [65536];
  logic [7:0] exp_q [$];
  logic [7:0] exp_page;

  int checks = 0;
  int failures = 0;

  // Observation log, written only by this monitor
  logic [7:0] cap_addr [$];
  logic [7:0] cap_data [$];
  int  stall_cnt = 0, done_cnt = 0, done_stray = 0, memwen_cnt = 0, page_err = 0;
  logic [7:0] done_addr = 8'h00;
  bit  prev_stall = 1'b0, first_par = 1'b0;
  always @(negedge clk) begin
    if (oam_wen) begin
      cap_addr.push_back(oam_addr);
      cap_data.push_back(oam_wdata);
    end
    if (dma_done) begin
      done_cnt++;
      done_addr = oam_addr;
      if (!oam_wen) done_stray++;
    end
    if (cpu_stall) begin
      if (!prev_stall) first_par = tb_par;
      stall_cnt++;
      if (mem_wen) memwen_cnt++;
      if (mem_raddr[15:8] != exp_page) page_err++;
    end
    prev_stall = cpu_stall;
  end

  int s_base, c_base, d_base, w_base, p_base;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_wen   = 1'b1;
    cpu_waddr = a;
    cpu_wdata = d;
    shadow[a] = d;
    @(posedge clk);
    #1;
    cpu_wen = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_raddr = a;
    @(posedge clk);
    @(negedge clk);
    d = cpu_rdata;
  endtask

  task automatic preload(input logic [7:0] page, input bit pattern);
    for (int i = 0; i < 256; i++)
      cpu_write({page, 8'(i)}, pattern ? (8'(i) ^ 8'h5A) : 8'($urandom_range(0, 255)));
  endtask

  // Issue the trigger write now; returns 1 ns after the trigger edge
  task automatic start_dma(input logic [7:0] page);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(shadow[{page, 8'(i)}]);
    exp_page = page;
    shadow[16'h4014] = page;
    s_base = stall_cnt; c_base = cap_addr.size(); d_base = done_cnt;
    w_base = memwen_cnt; p_base = page_err;
    cpu_wen = 1'b1; cpu_waddr = 16'h4014; cpu_wdata = page;
    @(posedge clk);
    #1;
    cpu_wen = 1'b0;
  endtask

  // Wait for the stall to end, then check length, OAM stream and done pulse
  task automatic finish_dma(input string nm, input int fixed_len);
    int len;
    bit timed_out;
    timed_out = 1'b1;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        timed_out = 1'b0;
        break;
      end
    end
    checks++;
    if (timed_out) begin
      failures++;
      $display("FAIL %s_timeout: cpu_stall still high after 700 cycles", nm);
    end
    len = stall_cnt - s_base;
    checks++;
    if (len !== 513 + int'(first_par)) begin
      failures++;
      $display("FAIL %s_stall_len: got %0d expected %0d", nm, len, 513 + int'(first_par));
    end
    if (fixed_len > 0) begin
      checks++;
      if (len !== fixed_len) begin
        failures++;
        $display("FAIL %s_stall_fixed: got %0d expected %0d", nm, len, fixed_len);
      end
    end
    checks++;
    if (cap_addr.size() - c_base !== 256) begin
      failures++;
      $display("FAIL %s_oam_count: got %0d expected 256", nm, cap_addr.size() - c_base);
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (c_base + i >= cap_addr.size()) begin
        failures++;
        $display("FAIL %s_oam_byte: index %0d missing expected data %02h", nm, i, e);
      end else if (cap_addr[c_base + i] !== 8'(i) || cap_data[c_base + i] !== e) begin
        failures++;
        $display("FAIL %s_oam_byte: got addr %02h data %02h expected addr %02h data %02h",
                 nm, cap_addr[c_base + i], cap_data[c_base + i], 8'(i), e);
      end
    end
    checks++;
    if (done_cnt - d_base !== 1 || done_addr !== 8'hFF || done_stray !== 0) begin
      failures++;
      $display("FAIL %s_done: got count %0d addr %02h stray %0d expected 1 FF 0",
               nm, done_cnt - d_base, done_addr, done_stray);
    end
    checks++;
    if (memwen_cnt - w_base !== 0 || page_err - p_base !== 0) begin
      failures++;
      $display("FAIL %s_bus: got mem_wen-in-stall %0d off-page reads %0d expected 0 0",
               nm, memwen_cnt - w_base, page_err - p_base);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    cpu_raddr = 16'($urandom_range(0, 65535));
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || oam_wen !== 1'b0 || oam_addr !== 8'h00 ||
        dma_done !== 1'b0 || mem_wen !== 1'b0 || mem_raddr !== cpu_raddr) begin
      failures++;
      $display("FAIL reset_outputs: got stall %b oam_wen %b oam_addr %02h done %b mem_wen %b raddr %04h expected 0 0 00 0 0 %04h",
               cpu_stall, oam_wen, oam_addr, dma_done, mem_wen, mem_raddr, cpu_raddr);
    end
    reset = 1'b0;
    tick();
    cpu_write(16'h1234, 8'hAB);
    cpu_read(16'h1234, d);
    checks++;
    if (d !== 8'hAB) begin
      failures++;
      $display("FAIL passthrough_read: got %02h expected AB", d);
    end
    checks++;
    if (stall_cnt !== 0 || cap_addr.size() !== 0) begin
      failures++;
      $display("FAIL idle_quiet: got stall cycles %0d oam writes %0d expected 0 0",
               stall_cnt, cap_addr.size());
    end
    tick();
  endtask

  task automatic test_even_dma();
    while (tb_par !== 1'b1) tick();
    start_dma(8'h02);
    finish_dma("even", 513);
  endtask

  task automatic test_odd_dma();
    tick();
    while (tb_par !== 1'b0) tick();
    start_dma(8'h02);
    finish_dma("odd", 514);
  endtask

  task automatic test_writes_ignored();
    logic [7:0] page, d, keep;
    page = 8'($urandom_range(8'h05, 8'h0F));
    preload(page, 1'b0);
    cpu_write(16'h0300, 8'($urandom_range(0, 255)));
    keep = shadow[16'h0300];
    repeat ($urandom_range(0, 3)) tick();
    start_dma(page);
    repeat ($urandom_range(20, 200)) tick();
    cpu_wen = 1'b1; cpu_waddr = 16'h4014; cpu_wdata = 8'h33;
    tick();
    cpu_waddr = 16'h0300; cpu_wdata = ~keep;
    tick();
    cpu_wen = 1'b0;
    finish_dma("ignore", 0);
    cpu_read(16'h0300, d);
    checks++;
    if (d !== keep) begin
      failures++;
      $display("FAIL ignore_mem0300: got %02h expected %02h", d, keep);
    end
    tick();
  endtask

  task automatic test_reset_mid_dma();
    logic [7:0] page, prev_page, page2;
    bit reached;
    int cb;
    prev_page = exp_page;
    page = 8'($urandom_range(8'h10, 8'h3F));
    preload(page, 1'b0);
    start_dma(page);
    cb = c_base;
    reached = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cap_addr.size() - cb >= 100) begin
        reached = 1'b1;
        break;
      end
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL midreset_progress: got %0d OAM writes expected 100", cap_addr.size() - cb);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b0 || oam_wen !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got stall %b oam_wen %b expected 0 0", cpu_stall, oam_wen);
    end
    reset = 1'b0;
    repeat (20) tick();
    checks++;
    if (cap_addr.size() - cb !== 100) begin
      failures++;
      $display("FAIL midreset_no_resume: got %0d OAM writes expected 100", cap_addr.size() - cb);
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] e;
      e = (i < 100) ? shadow[{page, 8'(i)}] : shadow[{prev_page, 8'(i)}];
      checks++;
      if (oam_m[i] !== e) begin
        failures++;
        $display("FAIL midreset_oam: index %0d got %02h expected %02h", i, oam_m[i], e);
      end
    end
    page2 = 8'($urandom_range(8'h10, 8'h3F));
    preload(page2, 1'b0);
    start_dma(page2);
    finish_dma("fresh", 0);
    tick();
  endtask

  task automatic test_back_to_back();
    preload(8'hFF, 1'b0);
    preload(8'h00, 1'b0);
    start_dma(8'hFF);
    finish_dma("pageff", 0);
    start_dma(8'h00);
    @(negedge clk);
    checks++;
    if (cpu_stall !== 1'b1) begin
      failures++;
      $display("FAIL retrigger_accept: got stall %b expected 1", cpu_stall);
    end
    finish_dma("page00", 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; cpu_wen = 1'b0; cpu_waddr = 16'h0000; cpu_wdata = 8'h00;
    cpu_raddr = 16'h0000; exp_page = 8'h00;
    for (int i = 0; i < 65536; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 65536; i++) mem_m[i] = 8'h00;
    for (int i = 0; i < 256; i++) oam_m[i] = 8'h00;
    test_reset();
    preload(8'h02, 1'b1);
    test_even_dma();
    test_odd_dma();
    test_writes_ignored();
    test_reset_mid_dma();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
